fifo_rr_drain_arbiter: RTL and testbench
========================================

Name: fifo_rr_drain_arbiter

Overview:
- Round-robin scheduler that drains NUM_SRC single-clock FIFO instances into one downstream valid/ready sink.
- Issues one-cycle get pulses to the granted FIFO and captures its registered data_out.
- Holds each grant for up to BURST words, then rotates.
- Sits between the per-source FIFO bank and the shared consumer (e.g. a link or packet framer).

Parameters:
- NUM_SRC, 4, number of FIFOs arbitrated (2..8).
- ADDR_WIDTH, 4, FIFO address width; each fillcount is ADDR_WIDTH+1 bits.
- WIDTH, 8, data word width.
- BURST, 4, maximum words taken from one source per grant (1..2^ADDR_WIDTH).

Ports:
- clk, input, 1, single clock, rising edge.
- reset, input, 1, synchronous, active-low; sampled only on the rising edge of clk.
- src_enable, input, NUM_SRC, per-source arbitration enable.
- fifo_fillcount, input, NUM_SRC*(ADDR_WIDTH+1), packed fillcounts; source i occupies bits [i*(ADDR_WIDTH+1) +: ADDR_WIDTH+1].
- fifo_data, input, NUM_SRC*WIDTH, packed FIFO data_out; source i occupies bits [i*WIDTH +: WIDTH].
- fifo_get, output, NUM_SRC, one-hot get pulses.
- out_data, output, WIDTH, word to the sink.
- out_src, output, log2(NUM_SRC) (min 1), index of the source that supplied out_data.
- out_valid, output, 1, out_data/out_src valid.
- out_ready, input, 1, sink accepts the word when out_valid && out_ready.
- busy, output, 1, high in every state except IDLE.

Behaviour:
- Request: req[i] = src_enable[i] && fifo_fillcount[i] != 0. Use fillcount, not the FIFO's registered empty flag, which lags by one cycle.
- Reset (reset==0 at a clk edge):
  - state = IDLE; fifo_get = 0; out_valid = 0; out_data = 0; out_src = 0; busy = 0.
  - burst_cnt = 0; last_grant = NUM_SRC-1, so source 0 has top priority after reset.
  - A word popped but not yet delivered is dropped.
- FSM states: IDLE, ISSUE, CAPTURE, HOLD.
- IDLE:
  - If any req, grant = first requesting index searching last_grant+1, last_grant+2, ... with wrap modulo NUM_SRC.
  - Register grant, set burst_cnt = 0, go to ISSUE.
  - If no req, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - fifo_get[grant] = 1; all other bits 0.
  - fifo_get is decoded from registered state and grant only, with no combinational path from inputs.
  - Go to CAPTURE.
- CAPTURE (exactly 1 cycle):
  - FIFO data_out is valid this cycle. At the edge: out_data <= fifo_data[grant], out_src <= grant, out_valid <= 1, burst_cnt <= burst_cnt+1.
  - Go to HOLD.
- HOLD:
  - out_valid stays 1; out_data and out_src stay stable until the handshake.
  - On the handshake (out_valid && out_ready): out_valid <= 0.
  - Then, if burst_cnt < BURST && req[grant] (using the updated fillcount), go to ISSUE with the same grant.
  - Otherwise set last_grant = grant and go to IDLE.
- Latency:
  - Req seen in IDLE at cycle c → get at c+1 → out_valid from c+3.
  - Back-to-back in a burst: handshake at cycle h → next get at h+1 → next out_valid at h+3.
  - Peak rate is 1 word per 3 cycles.
- Never more than one get outstanding; a get is never issued to a source whose fillcount is 0. This prevents underflow.
- src_enable deasserted mid-grant: the word in flight completes, then the grant is released at the HOLD handshake.
- Only one source is ever granted, so simultaneous requests are resolved purely by the round-robin order.
- A source that empties mid-burst is released early; rotation proceeds from that source.
- out_ready held low: stays in HOLD indefinitely, with no further gets and no data change.
- busy = (state != IDLE).

Test Plan:
- Reset, src 0 holds 3 words (0xA0..0xA2), others empty, out_ready=1 → gets to src 0 only; out_data 0xA0, 0xA1, 0xA2 with out_src=0; first out_valid 3 cycles after reset release; busy falls after the third handshake.
- All 4 sources hold 6 words, BURST=4, out_ready=1 → order src0×4, src1×4, src2×4, src3×4, src0×2, src1×2, ...; at most one fifo_get bit high at any time.
- out_ready low for 10 cycles during HOLD → out_valid and out_data stable, fifo_get stays 0; the word is delivered once on ready.
- src 2 holds 1 word while src 3 holds 5 → src2 delivers 1 word and is released early; the next grant goes to src 3.
- src_enable[1]=0 while src 1 is non-empty → src 1 is never granted; re-enable → src 1 is granted on its next turn in round-robin order.
- reset asserted during CAPTURE → next cycle out_valid=0, fifo_get=0, state IDLE; after release arbitration restarts at src 0.

Source files
------------

// File: rtl/fifo_rr_drain_arbiter.sv
// Round-robin drain scheduler: pulls up to BURST words per grant from NUM_SRC FIFOs
// and presents them one at a time to a single valid/ready sink.
module fifo_rr_drain_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int WIDTH      = 8,
  parameter int BURST      = 4,
  localparam int SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int FCW       = ADDR_WIDTH + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SRC-1:0]       src_enable,
  input  logic [NUM_SRC*FCW-1:0]   fifo_fillcount,
  input  logic [NUM_SRC*WIDTH-1:0] fifo_data,
  output logic [NUM_SRC-1:0]       fifo_get,
  output logic [WIDTH-1:0]         out_data,
  output logic [SRC_W-1:0]         out_src,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t             state_r;
  logic [SRC_W-1:0]   grant_r;
  logic [SRC_W-1:0]   last_grant_r;
  logic [FCW-1:0]     burst_cnt_r;
  logic [NUM_SRC-1:0] req_s;
  logic [SRC_W-1:0]   cand_s;
  logic [SRC_W-1:0]   pick_s;
  logic               pick_valid_s;
  logic [WIDTH-1:0]   sel_data_s;

  function automatic logic [NUM_SRC-1:0] onehot(input logic [SRC_W-1:0] idx);
    logic [NUM_SRC-1:0] v;
    for (int i = 0; i < NUM_SRC; i++) begin
      v[i] = (idx == SRC_W'(i));
    end
    return v;
  endfunction

  // Request per source; fillcount is used because the FIFO empty flag lags a cycle
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      req_s[i] = src_enable[i] && (fifo_fillcount[i*FCW +: FCW] != {FCW{1'b0}});
    end
  end

  // Round-robin search starting after last_grant; descending k lets the nearest win
  always_comb begin
    pick_valid_s = 1'b0;
    pick_s       = {SRC_W{1'b0}};
    cand_s       = {SRC_W{1'b0}};
    for (int k = NUM_SRC; k >= 1; k--) begin
      cand_s = SRC_W'((int'(last_grant_r) + k) % NUM_SRC);
      if (req_s[cand_s]) begin
        pick_valid_s = 1'b1;
        pick_s       = cand_s;
      end else begin
        pick_valid_s = pick_valid_s;
      end
    end
  end

  // Data mux for the granted source
  always_comb begin
    sel_data_s = {WIDTH{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_r == SRC_W'(i)) begin
        sel_data_s = fifo_data[i*WIDTH +: WIDTH];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
  end

  // Scheduler FSM with registered get pulses and sink outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= IDLE;
      grant_r      <= {SRC_W{1'b0}};
      last_grant_r <= SRC_W'(NUM_SRC - 1);
      burst_cnt_r  <= {FCW{1'b0}};
      fifo_get     <= {NUM_SRC{1'b0}};
      out_data     <= {WIDTH{1'b0}};
      out_src      <= {SRC_W{1'b0}};
      out_valid    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_valid_s) begin
            grant_r     <= pick_s;
            burst_cnt_r <= {FCW{1'b0}};
            fifo_get    <= onehot(pick_s);
            busy        <= 1'b1;
            state_r     <= ISSUE;
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          fifo_get <= {NUM_SRC{1'b0}};
          state_r  <= CAPTURE;
        end
        CAPTURE: begin
          out_data    <= sel_data_s;
          out_src     <= grant_r;
          out_valid   <= 1'b1;
          burst_cnt_r <= burst_cnt_r + FCW'(1);
          state_r     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            // fillcount here already reflects the word just popped
            if ((burst_cnt_r < FCW'(BURST)) && req_s[grant_r]) begin
              fifo_get <= onehot(grant_r);
              state_r  <= ISSUE;
            end else begin
              last_grant_r <= grant_r;
              busy         <= 1'b0;
              state_r      <= IDLE;
            end
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          fifo_get  <= {NUM_SRC{1'b0}};
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rr_drain_arbiter.sv
// Scoreboard bench: FIFO bank model, transaction-level round-robin reference, output monitor.
module tb_fifo_rr_drain_arbiter;
  localparam int N   = 4;
  localparam int AW  = 4;
  localparam int W   = 8;
  localparam int B   = 4;
  localparam int SW  = 2;
  localparam int FCW = AW + 1;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   src_enable;
  logic [N*FCW-1:0] fifo_fillcount;
  logic [N*W-1:0] fifo_data;
  logic [N-1:0]   fifo_get;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_src;
  logic           out_valid;
  logic           out_ready;
  logic           busy;

  fifo_rr_drain_arbiter #(.NUM_SRC(N), .ADDR_WIDTH(AW), .WIDTH(W), .BURST(B)) dut (
    .clk(clk), .reset(reset), .src_enable(src_enable), .fifo_fillcount(fifo_fillcount),
    .fifo_data(fifo_data), .fifo_get(fifo_get), .out_data(out_data), .out_src(out_src),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           fails = 0;
  logic [W-1:0] fq[N][$];
  logic [W-1:0] mq[N][$];
  logic [W-1:0] dout[N];
  logic [15:0]  sb[$];
  int           model_last = N - 1;
  int           ready_pct = 100;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic [SW-1:0] prev_src = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      fifo_fillcount[i*FCW +: FCW] = FCW'(fq[i].size());
      fifo_data[i*W +: W] = dout[i];
    end
  endtask

  // One clock: gets seen before the edge pop the FIFO model, which then presents data_out
  task automatic tick();
    logic [N-1:0] g;
    @(negedge clk);
    g = fifo_get;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (g[i] && fq[i].size() > 0) dout[i] = fq[i].pop_front();
    end
    out_ready = ($urandom_range(0, 99) < ready_pct);
    refresh();
  endtask

  task automatic load(input int s, input int n);
    logic [W-1:0] d;
    for (int j = 0; j < n; j++) begin
      d = W'($urandom);
      fq[s].push_back(d);
      mq[s].push_back(d);
    end
  endtask

  // Reference: grant next enabled non-empty source after the last one, take up to B words
  task automatic predict();
    int found;
    int n;
    while (1'b1) begin
      found = -1;
      for (int k = 1; k <= N; k++) begin
        if (found < 0 && src_enable[(model_last + k) % N] && mq[(model_last + k) % N].size() > 0)
          found = (model_last + k) % N;
      end
      if (found < 0) break;
      n = 0;
      while (n < B && mq[found].size() > 0) begin
        sb.push_back({8'(found), mq[found].pop_front()});
        n++;
      end
      model_last = found;
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      fq[i].delete();
      mq[i].delete();
      dout[i] = '0;
    end
    sb.delete();
    model_last = N - 1;
    refresh();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fifo_get", fifo_get, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_src", out_src, 0);
    chk("rst_busy", busy, 0);
    clear_model();
  endtask

  task automatic wait_drain(input string name, input int bound);
    int c;
    c = 0;
    while (c < bound && (sb.size() != 0 || busy)) begin
      tick();
      c++;
    end
    chk({name, "_drained"}, (sb.size() == 0 && !busy), 1);
    repeat (4) tick();
    chk({name, "_stays_idle"}, {busy, out_valid}, 0);
  endtask

  // Output monitor: scoreboard pop on handshake, stall stability, get legality
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
        chk("stall_src", out_src, prev_src);
        chk("stall_no_get", fifo_get, 0);
      end
      if (fifo_get != '0) begin
        chk("get_onehot", $countones(fifo_get), 1);
        for (int i = 0; i < N; i++) begin
          if (fifo_get[i]) chk("get_nonempty", (fq[i].size() != 0), 1);
        end
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_word: got src %0d data 0x%0h, expected no word", out_src, out_data);
        end else begin
          chk("out_src", out_src, sb[0][15:8]);
          chk("out_data", out_data, sb[0][7:0]);
          void'(sb.pop_front());
        end
      end
      prev_stall <= out_valid && !out_ready;
      prev_data  <= out_data;
      prev_src   <= out_src;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    int n;
    int room;
    reset = 1'b0;
    src_enable = '1;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) dout[i] = '0;
    refresh();

    // Source 0 alone, first-word latency
    do_reset();
    for (int j = 0; j < 3; j++) begin
      fq[0].push_back(8'(8'hA0 + j));
      mq[0].push_back(8'(8'hA0 + j));
    end
    refresh();
    predict();
    reset = 1'b1;
    tick();
    chk("t1_first_get", fifo_get, 4'b0001);
    tick();
    chk("t1_no_valid_yet", out_valid, 0);
    tick();
    chk("t1_first_valid", out_valid, 1);
    chk("t1_first_data", out_data, 8'hA0);
    wait_drain("t1", 100);

    // All sources full of 6 words, bursts rotate
    do_reset();
    for (int i = 0; i < N; i++) load(i, 6);
    refresh();
    predict();
    reset = 1'b1;
    wait_drain("t2", 600);

    // Sink stalls for 10 cycles in HOLD
    ready_pct = 0;
    out_ready = 1'b0;
    load(1, 2);
    refresh();
    predict();
    for (c = 0; c < 20 && !out_valid; c++) tick();
    chk("t3_valid_seen", out_valid, 1);
    repeat (10) tick();
    chk("t3_hold_valid", out_valid, 1);
    chk("t3_hold_get", fifo_get, 0);
    chk("t3_hold_data", out_data, sb[0][7:0]);
    ready_pct = 100;
    wait_drain("t3", 100);

    // Early release of a source that empties mid-burst
    load(2, 1);
    load(3, 5);
    refresh();
    predict();
    wait_drain("t4", 200);

    // Disabled source is skipped, then served after re-enable
    src_enable = 4'b1101;
    load(1, 4);
    load(0, 2);
    load(3, 2);
    refresh();
    predict();
    wait_drain("t5a", 200);
    chk("t5_src1_untouched", fq[1].size(), 4);
    src_enable = 4'b1111;
    load(2, 3);
    refresh();
    predict();
    wait_drain("t5b", 300);

    // Reset during CAPTURE drops the in-flight word and restarts at source 0
    load(1, 2);
    refresh();
    predict();
    for (c = 0; c < 20 && fifo_get == '0; c++) tick();
    chk("t6_issue_seen", fifo_get, 4'b0010);
    tick();
    reset = 1'b0;
    tick();
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_get", fifo_get, 0);
    chk("t6_rst_busy", busy, 0);
    tick();
    clear_model();
    load(0, 2);
    load(1, 2);
    load(3, 2);
    refresh();
    predict();
    reset = 1'b1;
    tick();
    chk("t6_restart_src0", fifo_get, 4'b0001);
    wait_drain("t6", 200);

    // Randomized phases: enable masks, fill levels, sink backpressure
    for (int p = 0; p < 10; p++) begin
      src_enable = 4'($urandom_range(1, 15));
      ready_pct = $urandom_range(30, 100);
      for (int i = 0; i < N; i++) begin
        room = 16 - fq[i].size();
        n = $urandom_range(0, 6);
        if (n > room) n = room;
        load(i, n);
      end
      refresh();
      predict();
      wait_drain("rand", 1500);
    end
    src_enable = '1;
    ready_pct = 100;
    predict();
    wait_drain("final", 1500);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
